// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of decode. It owns the PC,
// issues one instruction-memory read at a time over a req/resp handshake,
// builds the sign-extended immediate and tags fetch exceptions. It presents
// {inst, imm, pc, exception, mcause} to decode under a valid/ready handshake.
// A flush redirects the PC and throws away any in-flight work.
//
// Parameters
//   RESET_PC  first PC fetched after reset
//   NOP_INST  instruction word presented with a faulting fetch
//
// Ports
//   i_clock           clock, rising edge
//   i_reset           asynchronous, active-high reset
//   o_mem_req_valid   read request valid
//   o_mem_addr        request address (current PC)
//   i_mem_req_ready   memory accepts the request
//   i_mem_resp_valid  read data valid
//   i_mem_rdata       instruction word
//   i_mem_resp_err    access fault on this response
//   o_mem_resp_ready  response accepted (always 1)
//   o_inst            instruction to decode
//   o_imm             decoded immediate
//   o_pc              PC of o_inst
//   o_exception       fetch exception attached to the packet
//   o_mcause          0 = misaligned fetch, 1 = access fault
//   o_valid           packet valid to decode
//   i_ready           decode accepts the packet
//   i_flush           redirect request (highest priority)
//   i_redirect_pc     new PC when i_flush is high
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_resp_err,
  output logic        o_mem_resp_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic        o_exception,
  output logic [3:0]  o_mcause,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_flush,
  input  logic [31:0] i_redirect_pc
);

  typedef enum logic [2:0] {
    S_REQ,    // presenting a request for pc
    S_WAIT,   // request accepted, waiting for the response
    S_OUT,    // packet held for decode
    S_DRAIN,  // request accepted before a flush; swallow its response
    S_HALT    // fetch exception handed over; idle until redirected
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS     = 4'd1;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] inst_next, imm_next, pc_out_next;
  logic        exception_next;
  logic [3:0]  mcause_next;

  logic        aligned;
  logic        req_fire;
  logic        load_fault;  // misaligned PC: build a fault packet without memory
  logic        load_resp;   // capture a memory response into the packet

  // ---------------------------------------------------------------------------
  // Immediate generation, selected by opcode[6:2].
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] immgen(input logic [31:0] inst);
    logic [31:0] imm;
    case (inst[6:2])
      5'b00100, 5'b00000, 5'b11001, 5'b11100:             // I-type
        imm = {{20{inst[31]}}, inst[31:20]};
      5'b01000:                                           // S-type
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      5'b11000:                                           // B-type
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
               inst[11:8], 1'b0};
      5'b01101, 5'b00101:                                 // U-type
        imm = {inst[31:12], 12'b0};
      5'b11011:                                           // J-type
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
               inst[30:21], 1'b0};
      default:
        imm = 32'b0;
    endcase
    return imm;
  endfunction

  assign aligned  = (pc[1:0] == 2'b00);
  assign req_fire = (state == S_REQ) && aligned && i_mem_req_ready;

  // A flush suppresses any packet load in the same cycle, so the output
  // registers never change while the redirect is being taken.
  assign load_fault = (state == S_REQ)  && !aligned         && !i_flush;
  assign load_resp  = (state == S_WAIT) && i_mem_resp_valid && !i_flush;

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      o_inst      <= NOP_INST;
      o_imm       <= 32'b0;
      o_pc        <= RESET_PC;
      o_exception <= 1'b0;
      o_mcause    <= 4'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      o_inst      <= inst_next;
      o_imm       <= imm_next;
      o_pc        <= pc_out_next;
      o_exception <= exception_next;
      o_mcause    <= mcause_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold-value default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    inst_next      = o_inst;
    imm_next       = o_imm;
    pc_out_next    = o_pc;
    exception_next = o_exception;
    mcause_next    = o_mcause;

    if (load_fault) begin
      inst_next      = NOP_INST;
      imm_next       = 32'b0;
      pc_out_next    = pc;
      exception_next = 1'b1;
      mcause_next    = CAUSE_MISALIGNED;
    end

    if (load_resp) begin
      inst_next      = i_mem_resp_err ? NOP_INST : i_mem_rdata;
      imm_next       = immgen(i_mem_rdata);
      pc_out_next    = pc;
      exception_next = i_mem_resp_err;
      mcause_next    = i_mem_resp_err ? CAUSE_ACCESS : CAUSE_MISALIGNED;
    end

    case (state)
      S_REQ: begin
        if (!aligned)             state_next = S_OUT;
        else if (i_mem_req_ready) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_resp_valid) state_next = S_OUT;
      end
      S_OUT: begin
        if (i_ready) begin
          if (o_exception) begin
            state_next = S_HALT;
          end else begin
            state_next = S_REQ;
            pc_next    = pc + 32'd4;
          end
        end
      end
      S_DRAIN: begin
        if (i_mem_resp_valid) state_next = S_REQ;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase

    // Flush overrides everything above. A request already accepted (or being
    // accepted this cycle) still owes a response, which DRAIN absorbs; a
    // response arriving alongside the flush settles that debt immediately.
    if (i_flush) begin
      pc_next = i_redirect_pc;
      case (state)
        S_WAIT, S_DRAIN: state_next = i_mem_resp_valid ? S_REQ : S_DRAIN;
        S_REQ:           state_next = req_fire ? S_DRAIN : S_REQ;
        default:         state_next = S_REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_mem_req_valid  = (state == S_REQ) && aligned;
    o_mem_addr       = pc;
    o_mem_resp_ready = 1'b1;
    o_valid          = (state == S_OUT);
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_req_ready;
  logic        i_mem_resp_valid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_resp_err;
  logic        o_mem_resp_ready;
  logic [31:0] o_inst;
  logic [31:0] o_imm;
  logic [31:0] o_pc;
  logic        o_exception;
  logic [3:0]  o_mcause;
  logic        o_valid;
  logic        i_ready;
  logic        i_flush;
  logic [31:0] i_redirect_pc;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .o_mem_req_valid  (o_mem_req_valid),
    .o_mem_addr       (o_mem_addr),
    .i_mem_req_ready  (i_mem_req_ready),
    .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_rdata      (i_mem_rdata),
    .i_mem_resp_err   (i_mem_resp_err),
    .o_mem_resp_ready (o_mem_resp_ready),
    .o_inst           (o_inst),
    .o_imm            (o_imm),
    .o_pc             (o_pc),
    .o_exception      (o_exception),
    .o_mcause         (o_mcause),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .i_flush          (i_flush),
    .i_redirect_pc    (i_redirect_pc)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    string       name;
    logic [31:0] inst;     // word returned by memory
    int          hold;     // cycles decode stalls before accepting
    logic [31:0] exp_inst;
    logic [31:0] exp_imm;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_pc;
  vec_t        vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_halted(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check({name, " req_valid"}, o_mem_req_valid, 0);
      check({name, " valid"}, o_valid, 0);
    end
  endtask

  // One complete fetch with a 1-cycle memory: request accepted, response the
  // next cycle, packet checked, optional stall, then transfer to decode.
  task automatic fetch(input string name, input logic [31:0] data,
                       input logic err, input int hold,
                       input logic [31:0] e_inst, input logic [31:0] e_imm,
                       input logic e_exc, input logic [3:0] e_cause);
    int n = 0;
    while (!o_mem_req_valid && n < 20) begin
      step();
      n++;
    end
    check({name, " req_valid"}, o_mem_req_valid, 1);
    check({name, " addr"}, o_mem_addr, exp_pc);
    step();                              // request accepted here
    check({name, " no_req_in_wait"}, o_mem_req_valid, 0);
    i_mem_resp_valid = 1'b1;
    i_mem_rdata      = data;
    i_mem_resp_err   = err;
    step();
    i_mem_resp_valid = 1'b0;
    i_mem_resp_err   = 1'b0;
    check({name, " valid"}, o_valid, 1);
    check({name, " inst"}, o_inst, e_inst);
    check({name, " imm"}, o_imm, e_imm);
    check({name, " pc"}, o_pc, exp_pc);
    check({name, " exc"}, o_exception, e_exc);
    check({name, " mcause"}, o_mcause, e_cause);
    for (int i = 0; i < hold; i++) begin
      step();
      check({name, " hold valid"}, o_valid, 1);
      check({name, " hold inst"}, o_inst, e_inst);
      check({name, " hold imm"}, o_imm, e_imm);
      check({name, " hold pc"}, o_pc, exp_pc);
      check({name, " hold no_req"}, o_mem_req_valid, 0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    if (!e_exc) exp_pc = exp_pc + 32'd4;
    check({name, " valid_drop"}, o_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{"addi",      32'h0050_0093, 0, 32'h0050_0093, 32'h0000_0005};
    vecs[1]  = '{"beq_stall", 32'hFE00_0EE3, 5, 32'hFE00_0EE3, 32'hFFFF_FFFC};
    vecs[2]  = '{"sw_neg",    32'hFE51_2C23, 0, 32'hFE51_2C23, 32'hFFFF_FFF8};
    vecs[3]  = '{"lui",       32'h1234_50B7, 0, 32'h1234_50B7, 32'h1234_5000};
    vecs[4]  = '{"auipc_neg", 32'hFFFF_F097, 1, 32'hFFFF_F097, 32'hFFFF_F000};
    vecs[5]  = '{"jal_pos",   32'h0010_00EF, 0, 32'h0010_00EF, 32'h0000_0800};
    vecs[6]  = '{"jal_neg",   32'hFFDF_F06F, 0, 32'hFFDF_F06F, 32'hFFFF_FFFC};
    vecs[7]  = '{"lw_neg",    32'hFFF1_2083, 0, 32'hFFF1_2083, 32'hFFFF_FFFF};
    vecs[8]  = '{"jalr",      32'h7FF0_80E7, 0, 32'h7FF0_80E7, 32'h0000_07FF};
    vecs[9]  = '{"csrrw",     32'h3401_1073, 0, 32'h3401_1073, 32'h0000_0340};
    vecs[10] = '{"add_none",  32'h0020_81B3, 2, 32'h0020_81B3, 32'h0000_0000};

    i_reset          = 1'b1;
    i_mem_req_ready  = 1'b1;
    i_mem_resp_valid = 1'b0;
    i_mem_rdata      = 32'h0;
    i_mem_resp_err   = 1'b0;
    i_ready          = 1'b0;
    i_flush          = 1'b0;
    i_redirect_pc    = 32'h0;
    exp_pc           = RESET_PC;

    // Reset state.
    step();
    step();
    check("rst valid", o_valid, 0);
    check("rst inst", o_inst, NOP_INST);
    check("rst imm", o_imm, 0);
    check("rst pc", o_pc, RESET_PC);
    check("rst exc", o_exception, 0);
    check("rst mcause", o_mcause, 0);
    check("rst resp_ready", o_mem_resp_ready, 1);
    i_reset = 1'b0;

    // Immediate generation and back-pressure over the vector table.
    foreach (vecs[k])
      fetch(vecs[k].name, vecs[k].inst, 1'b0, vecs[k].hold,
            vecs[k].exp_inst, vecs[k].exp_imm, 1'b0, 4'd0);

    // Flush while waiting: the late response must be discarded.
    step();                              // request accepted
    i_flush = 1'b1;
    i_redirect_pc = 32'h8000_0100;
    step();
    i_flush = 1'b0;
    exp_pc = 32'h8000_0100;
    check("drain valid", o_valid, 0);
    check("drain no_req", o_mem_req_valid, 0);
    step();
    check("drain still_waiting", o_mem_req_valid, 0);
    i_mem_resp_valid = 1'b1;
    i_mem_rdata = 32'h0050_0093;
    step();
    i_mem_resp_valid = 1'b0;
    check("drain late_valid", o_valid, 0);
    check("drain redirect_req", o_mem_req_valid, 1);
    check("drain redirect_addr", o_mem_addr, 32'h8000_0100);
    fetch("after_drain", 32'h0050_0093, 1'b0, 0, 32'h0050_0093, 32'h5, 1'b0, 4'd0);

    // Flush in the same cycle the request is accepted: must still drain.
    i_flush = 1'b1;
    i_redirect_pc = 32'h8000_0180;
    step();
    i_flush = 1'b0;
    exp_pc = 32'h8000_0180;
    check("acc_flush no_req", o_mem_req_valid, 0);
    i_mem_resp_valid = 1'b1;
    step();
    i_mem_resp_valid = 1'b0;
    check("acc_flush valid", o_valid, 0);
    check("acc_flush addr", o_mem_addr, 32'h8000_0180);

    // Flush together with a transfer: transfer completes, no pc += 4.
    step();
    i_mem_resp_valid = 1'b1;
    i_mem_rdata = 32'h1234_50B7;
    step();
    i_mem_resp_valid = 1'b0;
    check("xfer_flush valid", o_valid, 1);
    check("xfer_flush pc", o_pc, 32'h8000_0180);
    i_ready = 1'b1;
    i_flush = 1'b1;
    i_redirect_pc = 32'h8000_0300;
    step();
    i_ready = 1'b0;
    i_flush = 1'b0;
    exp_pc = 32'h8000_0300;
    check("xfer_flush valid_drop", o_valid, 0);
    check("xfer_flush addr", o_mem_addr, 32'h8000_0300);

    // Access fault: packet tagged, then fetch halts until redirected.
    fetch("acc_fault", 32'hDEAD_0033, 1'b1, 0, NOP_INST, 32'h0, 1'b1, 4'd1);
    check_halted("halt_fault", 4);
    i_flush = 1'b1;
    i_redirect_pc = 32'h8000_0200;
    step();
    i_flush = 1'b0;
    exp_pc = 32'h8000_0200;
    fetch("resume", 32'h0050_0093, 1'b0, 0, 32'h0050_0093, 32'h5, 1'b0, 4'd0);

    // Misaligned redirect: no memory request, fault packet instead.
    i_mem_req_ready = 1'b0;
    i_flush = 1'b1;
    i_redirect_pc = 32'h8000_0102;
    step();
    i_flush = 1'b0;
    i_mem_req_ready = 1'b1;
    check("misal no_req", o_mem_req_valid, 0);
    step();
    check("misal valid", o_valid, 1);
    check("misal exc", o_exception, 1);
    check("misal mcause", o_mcause, 0);
    check("misal pc", o_pc, 32'h8000_0102);
    check("misal inst", o_inst, NOP_INST);
    check("misal imm", o_imm, 0);
    check("misal no_req_out", o_mem_req_valid, 0);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check_halted("halt_misal", 3);

    // PC wraps from FFFF_FFFC to 0.
    i_flush = 1'b1;
    i_redirect_pc = 32'hFFFF_FFFC;
    step();
    i_flush = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    fetch("wrap_top", 32'h0050_0093, 1'b0, 0, 32'h0050_0093, 32'h5, 1'b0, 4'd0);
    fetch("wrap_zero", 32'h1234_50B7, 1'b0, 0, 32'h1234_50B7, 32'h1234_5000,
          1'b0, 4'd0);

    // Reset while waiting: immediate return to reset values, stale response ignored.
    step();                              // request accepted
    i_reset = 1'b1;
    #1;
    check("wait_rst valid", o_valid, 0);
    check("wait_rst inst", o_inst, NOP_INST);
    check("wait_rst pc", o_pc, RESET_PC);
    check("wait_rst exc", o_exception, 0);
    check("wait_rst addr", o_mem_addr, RESET_PC);
    step();
    i_reset = 1'b0;
    i_mem_req_ready = 1'b0;
    i_mem_resp_valid = 1'b1;
    i_mem_rdata = 32'hFE00_0EE3;
    step();
    i_mem_resp_valid = 1'b0;
    i_mem_req_ready = 1'b1;
    check("stale valid", o_valid, 0);
    check("stale req", o_mem_req_valid, 1);
    exp_pc = RESET_PC;
    fetch("post_rst", 32'h0050_0093, 1'b0, 0, 32'h0050_0093, 32'h5, 1'b0, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck design still reaches a summary line.
  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no_finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
